// File: rtl/edl_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : edl_encoder_pkg
//  Brief    : Shared constants, direction type and quadrature helpers for the
//             edl_encoder_ctrl wheel encoder controller.
//  Revision : 1.0 - initial release
// ============================================================================
package edl_encoder_pkg;

  // Avalon word addresses
  localparam logic [1:0] REG_POSITION = 2'd0;
  localparam logic [1:0] REG_VELOCITY = 2'd1;
  localparam logic [1:0] REG_CONTROL  = 2'd2;
  localparam logic [1:0] REG_WINDOW   = 2'd3;

  // CONTROL register bit positions
  localparam int CTL_ENABLE = 0;
  localparam int CTL_INVERT = 1;
  localparam int CTL_IDXCLR = 2;
  localparam int CTL_ERROR  = 8;
  localparam int CTL_ERRCLR = 30;
  localparam int CTL_POSCLR = 31;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_UP      = 2'd1,
    DIR_DOWN    = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_t;

  // Position of an {A,B} pair along the forward cycle 00 -> 01 -> 11 -> 10
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // One step forward is +1 around the cycle, one step back is +3 (mod 4),
  // a jump of two means both lines toggled at once.
  function automatic dir_t decode_dir(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic [1:0] diff;
    dir_t       dir;
    diff = gray_idx(cur_ab) - gray_idx(prev_ab);
    case (diff)
      2'd0:    dir = DIR_NONE;
      2'd1:    dir = DIR_UP;
      2'd3:    dir = DIR_DOWN;
      default: dir = DIR_ILLEGAL;
    endcase
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edl_encoder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : edl_encoder_ctrl_if
//  Brief    : Avalon-MM slave bus (4 words, 1-cycle read latency) used by
//             edl_encoder_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface edl_encoder_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/edl_input_filter.sv
`default_nettype none
// ============================================================================
//  Module   : edl_input_filter
//  Brief    : Two-flop synchroniser followed by a stability filter. The output
//             follows the input only after FILTER_LEN consecutive synced
//             samples disagree with the current output.
//  Revision : 1.0 - initial release
// ============================================================================
module edl_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_out;
  logic          w_sample;

  assign w_sample = r_sync[1];
  assign dout     = r_out;

  // Bring the asynchronous line into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], din};
  end

  // Count consecutive samples that differ from the output; any agreeing sample restarts the run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (w_sample != r_out) begin
      if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_out <= w_sample;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/edl_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : edl_encoder_ctrl
//  Brief    : Quadrature encoder controller for one wheel: input filtering,
//             32-bit position decode, windowed velocity and an Avalon-MM
//             register file (POSITION, VELOCITY, CONTROL, WINDOW).
//             Optional macro ENC_INDEX_EN adds the enc_z index input which
//             can clear position on its filtered rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module edl_encoder_ctrl
  import edl_encoder_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int DEFAULT_WINDOW = 50000,
  parameter int MIN_WINDOW     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enc_a,
  input  logic              enc_b,
`ifdef ENC_INDEX_EN
  input  logic              enc_z,
`endif
  edl_encoder_ctrl_if.slave bus
);

  logic        w_filt_a, w_filt_b, w_filt_z;
  logic [1:0]  w_ab;
  logic [1:0]  r_ab_prev;
  dir_t        w_dir;
  logic        r_enable, r_invert, r_error;
  logic        w_idxclr_bit;
  logic        w_idx_clr;
  logic [31:0] r_position, r_snapshot, r_velocity;
  logic [31:0] r_window, r_win_cnt;
  logic [31:0] w_pos_next;
  logic [31:0] w_win_wr_val;
  logic [31:0] w_ctl_rd;
  logic        w_wr, w_wr_ctl, w_wr_win;
  logic        w_soft_clr, w_pos_clr, w_win_expire;

  edl_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .reset_n(reset_n), .din(enc_a), .dout(w_filt_a)
  );
  edl_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .reset_n(reset_n), .din(enc_b), .dout(w_filt_b)
  );

`ifdef ENC_INDEX_EN
  logic r_idxclr_en;
  logic r_z_prev;

  edl_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_z (
    .clk(clk), .reset_n(reset_n), .din(enc_z), .dout(w_filt_z)
  );

  // Index clear enable bit and previous filtered Z for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idxclr_en <= 1'b0;
      r_z_prev    <= 1'b0;
    end else begin
      r_z_prev <= w_filt_z;
      if (w_wr_ctl) r_idxclr_en <= bus.writedata[CTL_IDXCLR];
    end
  end

  assign w_idxclr_bit = r_idxclr_en;
  assign w_idx_clr    = r_idxclr_en & w_filt_z & ~r_z_prev;
`else
  assign w_filt_z     = 1'b0;
  assign w_idxclr_bit = 1'b0;
  assign w_idx_clr    = 1'b0;
`endif

  assign w_ab  = {w_filt_a, w_filt_b};
  assign w_dir = decode_dir(r_ab_prev, w_ab);

  assign w_wr         = bus.chipselect & ~bus.write_n;
  assign w_wr_ctl     = w_wr && (bus.address == REG_CONTROL);
  assign w_wr_win     = w_wr && (bus.address == REG_WINDOW);
  assign w_soft_clr   = w_wr_ctl & bus.writedata[CTL_POSCLR];
  assign w_pos_clr    = w_soft_clr | w_idx_clr;
  assign w_win_expire = ~w_wr_win && (r_win_cnt == 32'd0);
  assign w_win_wr_val = (bus.writedata < 32'(MIN_WINDOW)) ? 32'(MIN_WINDOW) : bus.writedata;

  // Next position from one decoded step, sign swapped when inverted
  always_comb begin
    w_pos_next = r_position;
    if (r_enable) begin
      case (w_dir)
        DIR_UP:   w_pos_next = r_invert ? r_position - 32'd1 : r_position + 32'd1;
        DIR_DOWN: w_pos_next = r_invert ? r_position + 32'd1 : r_position - 32'd1;
        default:  w_pos_next = r_position;
      endcase
    end
  end

  // Decoder state tracks the filtered lines even while counting is disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ab_prev <= 2'b00;
    else          r_ab_prev <= w_ab;
  end

  // CONTROL bits; a new illegal transition wins over a same-cycle error clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b1;
      r_invert <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      if (w_wr_ctl) begin
        r_enable <= bus.writedata[CTL_ENABLE];
        r_invert <= bus.writedata[CTL_INVERT];
      end
      if (w_dir == DIR_ILLEGAL)                    r_error <= 1'b1;
      else if (w_wr_ctl && bus.writedata[CTL_ERRCLR]) r_error <= 1'b0;
    end
  end

  // Position: clear has priority over a coincident count step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_position <= 32'd0;
    else if (w_pos_clr) r_position <= 32'd0;
    else                r_position <= w_pos_next;
  end

  // Snapshot follows position at each window end, and clears with position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_snapshot <= 32'd0;
    else if (w_pos_clr)    r_snapshot <= 32'd0;
    else if (w_win_expire) r_snapshot <= r_position;
  end

  // Window register, down-counter and velocity; a WINDOW write restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window   <= 32'(DEFAULT_WINDOW);
      r_win_cnt  <= 32'(DEFAULT_WINDOW - 1);
      r_velocity <= 32'd0;
    end else if (w_wr_win) begin
      r_window  <= w_win_wr_val;
      r_win_cnt <= w_win_wr_val - 32'd1;
    end else if (w_win_expire) begin
      r_velocity <= r_position - r_snapshot;
      r_win_cnt  <= r_window - 32'd1;
    end else begin
      r_win_cnt <= r_win_cnt - 32'd1;
    end
  end

  assign w_ctl_rd = {23'd0, r_error, w_filt_z, w_filt_a, w_filt_b, 2'b00,
                     w_idxclr_bit, r_invert, r_enable};

  // Registered read mux, refreshed every clock
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'd0;
    end else begin
      case (bus.address)
        REG_POSITION: bus.readdata <= r_position;
        REG_VELOCITY: bus.readdata <= r_velocity;
        REG_CONTROL:  bus.readdata <= w_ctl_rd;
        default:      bus.readdata <= r_window;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edl_encoder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edl_encoder_ctrl
//  Brief    : Directed self-checking bench for edl_encoder_ctrl (both with
//             and without ENC_INDEX_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edl_encoder_ctrl;
  import edl_encoder_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enc_a   = 1'b0;
  logic enc_b   = 1'b0;
`ifdef ENC_INDEX_EN
  logic enc_z   = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int qidx     = 0;
  logic [1:0]  qseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [31:0] rdv;

  edl_encoder_ctrl_if bus ();

  edl_encoder_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
`ifdef ENC_INDEX_EN
    .enc_z   (enc_z),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    @(posedge clk); #1;
    d = bus.readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic step_enc(input int dirn, input int n, input int hold);
    for (int i = 0; i < n; i++) begin
      qidx = (qidx + dirn) & 3;
      {enc_a, enc_b} = qseq[qidx];
      repeat (hold) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.address    = REG_WINDOW;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;

    // ---- reset state
    repeat (3) @(posedge clk); #1;
    chk("reset_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    rd(REG_POSITION, rdv); chk("reset_position", rdv, 32'd0);
    rd(REG_VELOCITY, rdv); chk("reset_velocity", rdv, 32'd0);
    rd(REG_WINDOW,   rdv); chk("reset_window",   rdv, 32'd50000);
    rd(REG_CONTROL,  rdv); chk("reset_control",  rdv, 32'h0000_0001);

    // ---- forward counting, filtered input bits visible in CONTROL
    step_enc(1, 2, 8);
    rd(REG_POSITION, rdv); chk("fwd2_position", rdv, 32'd2);
    rd(REG_CONTROL,  rdv); chk("fwd2_control_ab11", rdv, 32'h0000_0061);
    step_enc(1, 38, 8);
    rd(REG_POSITION, rdv); chk("fwd40_position", rdv, 32'd40);
    rd(REG_CONTROL,  rdv); chk("fwd40_control", rdv, 32'h0000_0001);
    wr(REG_POSITION, 32'h0000_1234);
    rd(REG_POSITION, rdv); chk("position_readonly", rdv, 32'd40);

    // ---- inverted counting and glitch rejection
    wr(REG_CONTROL, 32'h8000_0003);
    rd(REG_CONTROL,  rdv); chk("posclr_selfclear", rdv, 32'h0000_0003);
    rd(REG_POSITION, rdv); chk("softclr_position", rdv, 32'd0);
    step_enc(1, 40, 8);
    rd(REG_POSITION, rdv); chk("invert_position", rdv, 32'hFFFF_FFD8);
    enc_a = 1'b1;
    repeat (2) @(posedge clk); #1;
    enc_a = 1'b0;
    repeat (10) @(posedge clk); #1;
    rd(REG_POSITION, rdv); chk("glitch_position", rdv, 32'hFFFF_FFD8);
    rd(REG_CONTROL,  rdv); chk("glitch_control", rdv, 32'h0000_0003);

    // ---- illegal transition sets sticky error
    wr(REG_CONTROL, 32'h0000_0001);
    enc_a = 1'b1; enc_b = 1'b1;
    repeat (10) @(posedge clk); #1;
    rd(REG_POSITION, rdv); chk("illegal_position", rdv, 32'hFFFF_FFD8);
    rd(REG_CONTROL,  rdv); chk("illegal_error_set", rdv, 32'h0000_0161);
    enc_a = 1'b0; enc_b = 1'b0;
    repeat (10) @(posedge clk); #1;
    rd(REG_CONTROL,  rdv); chk("error_sticky", rdv, 32'h0000_0101);
    wr(REG_CONTROL, 32'h4000_0001);
    rd(REG_CONTROL,  rdv); chk("error_cleared", rdv, 32'h0000_0001);

    // ---- velocity over a 1000-cycle window, window clamp
    wr(REG_CONTROL, 32'h8000_0001);
    wr(REG_WINDOW, 32'd1000);
    step_enc(1, 25, 100);
    rd(REG_VELOCITY, rdv); chk("velocity_10", rdv, 32'd10);
    rd(REG_POSITION, rdv); chk("velocity_position", rdv, 32'd25);
    rd(REG_WINDOW,   rdv); chk("window_1000", rdv, 32'd1000);
    wr(REG_WINDOW, 32'd5);
    rd(REG_WINDOW,   rdv); chk("window_clamp", rdv, 32'd16);
    wr(REG_WINDOW, 32'd17);
    rd(REG_WINDOW,   rdv); chk("window_17", rdv, 32'd17);

    // ---- wrap below zero, clear coincident with a count step
    wr(REG_CONTROL, 32'h8000_0001);
    step_enc(-1, 2, 8);
    rd(REG_POSITION, rdv); chk("wrap_fffffffe", rdv, 32'hFFFF_FFFE);
    qidx = (qidx - 1) & 3;
    {enc_a, enc_b} = qseq[qidx];
    repeat (6) @(posedge clk); #1;
    wr(REG_CONTROL, 32'h8000_0001);
    repeat (10) @(posedge clk); #1;
    rd(REG_POSITION, rdv); chk("clear_beats_step", rdv, 32'd0);
    step_enc(-1, 1, 8);
    rd(REG_POSITION, rdv); chk("wrap_ffffffff", rdv, 32'hFFFF_FFFF);
    step_enc(1, 4, 8);
    rd(REG_POSITION, rdv); chk("wrap_back_up", rdv, 32'd3);

    // ---- index clear option
`ifdef ENC_INDEX_EN
    wr(REG_CONTROL, 32'h0000_0005);
    rd(REG_CONTROL,  rdv); chk("idxclr_en_readback", rdv, 32'h0000_0005 | {25'd0, qseq[qidx], 5'd0});
    enc_z = 1'b1;
    repeat (8) @(posedge clk); #1;
    enc_z = 1'b0;
    repeat (8) @(posedge clk); #1;
    rd(REG_POSITION, rdv); chk("index_clear", rdv, 32'd0);
`else
    wr(REG_CONTROL, 32'h0000_0005);
    rd(REG_CONTROL,  rdv); chk("idxclr_absent", rdv, 32'h0000_0001 | {25'd0, qseq[qidx], 5'd0});
    rd(REG_POSITION, rdv); chk("no_index_position", rdv, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
